mem_port_arbiter: RTL and testbench

- Shares the single-ported main memory between the instruction-fetch requester (IF) and the load/store requester (D).
- Sits between the core's fetch/LSU front-ends and main memory.
- Grants at most one access per cycle and captures the combinational read data into a per-requester response register.
- Enforces the memory's write encoding (reads drive zero write data) and bounds fetch starvation.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_rsp_slot.sv | 33 +++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the IF / load-store memory port arbiter.
package mem_pkg;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    localparam logic [31:0] NOP_WORD          = 32'h00000013;
    localparam int          MEM_BYTES_DEFAULT = 1024;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    // A store of zero would silently be dropped by the memory, so it is refused up front.
    function automatic logic req_bad(
        input logic [31:0] addr,
        input logic        we,
        input logic [31:0] wdata,
        input logic [31:0] mem_bytes
    );
        return (addr[1:0] != 2'b00) || (addr >= mem_bytes) || (we && (wdata == 32'd0));
    endfunction

endpackage

// File: rtl/mem_rsp_slot.sv
// One requester's response register: loads on accept, holds until the consumer drains it.
module mem_rsp_slot
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_err,
    input  logic        rsp_ready,
    output rsp_t        rsp,
    output logic        free
);

    rsp_t rsp_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_reg <= '0;
        end else if (load) begin
            rsp_reg.valid <= 1'b1;
            rsp_reg.data  <= load_data;
            rsp_reg.err   <= load_err;
        end else if (rsp_ready) begin
            rsp_reg.valid <= 1'b0;
        end
    end

    assign rsp  = rsp_reg;
    // A draining slot may be refilled in the same cycle, so back-to-back accepts see no bubble.
    assign free = !rsp_reg.valid || rsp_ready;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported main memory between instruction fetch and load/store,
// with a round-robin tie-break and a bound on fetch starvation.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_BYTES    = MEM_BYTES_DEFAULT,
    parameter int STARVE_LIMIT = 4,
    parameter int RESET_PRIO_D = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam logic [31:0] MEM_LIMIT  = 32'(MEM_BYTES);
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_LIMIT);
    localparam req_id_e     PRIO_INIT  = (RESET_PRIO_D != 0) ? REQ_D : REQ_IF;

    rsp_t        if_rsp;
    rsp_t        d_rsp;
    logic        if_free;
    logic        d_free;
    logic        if_elig;
    logic        d_elig;
    logic        contested;
    logic        grant_if;
    logic        grant_d;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [31:0] sel_wdata;
    logic        acc_any;
    logic        acc_bad;
    logic        acc_good;
    logic [31:0] load_data;

    logic [3:0]  starve_cnt_reg;
    logic [3:0]  starve_cnt_next;
    req_id_e     prio_reg;
    req_id_e     prio_next;

    // Nothing is granted while reset is held so the memory stays idle.
    assign if_elig   = if_req_valid && if_free && !reset;
    assign d_elig    = d_req_valid  && d_free  && !reset;
    assign contested = if_elig && d_elig;

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (contested) begin
            if (starve_cnt_reg >= STARVE_LIM) begin
                grant_if = 1'b1;
            end else if (prio_reg == REQ_D) begin
                grant_d = 1'b1;
            end else begin
                grant_if = 1'b1;
            end
        end else begin
            grant_if = if_elig;
            grant_d  = d_elig;
        end
    end

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    assign sel_addr  = grant_d ? d_req_addr : if_req_addr;
    assign sel_we    = grant_d && d_req_we;
    assign sel_wdata = grant_d ? d_req_wdata : 32'd0;
    assign acc_any   = grant_if || grant_d;
    assign acc_bad   = acc_any && req_bad(sel_addr, sel_we, sel_wdata, MEM_LIMIT);
    assign acc_good  = acc_any && !acc_bad;

    assign mem_en      = acc_good;
    assign mem_addr    = acc_good ? sel_addr : 32'd0;
    assign mem_data_in = (acc_good && sel_we) ? sel_wdata : 32'd0;
    assign load_data   = (acc_good && !sel_we) ? mem_data_out : 32'd0;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        prio_next       = prio_reg;
        if (grant_if) begin
            starve_cnt_next = 4'd0;
        end else if (if_elig && grant_d && (starve_cnt_reg != 4'hF)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
        if (contested) begin
            prio_next = grant_d ? REQ_IF : REQ_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_reg <= 4'd0;
            prio_reg       <= PRIO_INIT;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            prio_reg       <= prio_next;
        end
    end

    mem_rsp_slot u_if_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (grant_if),
        .load_data (load_data),
        .load_err  (acc_bad),
        .rsp_ready (if_rsp_ready),
        .rsp       (if_rsp),
        .free      (if_free)
    );

    mem_rsp_slot u_d_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (grant_d),
        .load_data (load_data),
        .load_err  (acc_bad),
        .rsp_ready (d_rsp_ready),
        .rsp       (d_rsp),
        .free      (d_free)
    );

    assign if_rsp_valid = if_rsp.valid;
    assign if_rsp_data  = if_rsp.data;
    assign if_rsp_err   = if_rsp.err;
    assign d_rsp_valid  = d_rsp.valid;
    assign d_rsp_data   = d_rsp.data;
    assign d_rsp_err    = d_rsp.err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a cycle-level model.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic        if_rsp_ready;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic        d_rsp_ready;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_ready  (d_rsp_ready),
        .d_rsp_data   (d_rsp_data),
        .d_rsp_err    (d_rsp_err),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory: combinational read, write on enable with non-zero data.
    logic [31:0] mem_arr [256];
    logic        init_mem;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h00100093;
            1:       return 32'h00200113;
            2:       return 32'h00300193;
            default: return NOP_WORD | (32'(i) << 7);
        endcase
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
        end else if (mem_en && (mem_data_in != 32'd0) && (mem_addr < 32'd1024)) begin
            mem_arr[mem_addr[9:2]] <= mem_data_in;
        end
    end
    assign mem_data_out = mem_arr[mem_addr[9:2]];

    // Reference model state
    logic        m_if_v, m_if_err, m_d_v, m_d_err, m_prio_d;
    logic [31:0] m_if_data, m_d_data;
    int          m_starve;
    logic [31:0] shadow [256];

    task automatic idle_inputs();
        if_req_valid = 1'b0; if_req_addr = 32'd0; if_rsp_ready = 1'b1;
        d_req_valid  = 1'b0; d_req_we = 1'b0; d_req_addr = 32'd0; d_req_wdata = 32'd0;
        d_rsp_ready  = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return 32'h400 + (32'($urandom_range(0, 1000)) << 2);
        return 32'($urandom_range(0, 31)) << 2;
    endfunction

    task automatic test_reset();
        reset = 1'b1; init_mem = 1'b1;
        idle_inputs();
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        init_mem = 1'b0;
        total++; if (if_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%0b exp=0", if_rsp_valid); end
        total++; if (d_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_d_valid got=%0b exp=0", d_rsp_valid); end
        total++; if (if_rsp_data !== 32'd0 || if_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_if_rsp got=%0h/%0b exp=0/0", if_rsp_data, if_rsp_err); end
        total++; if (d_rsp_data !== 32'd0 || d_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_d_rsp got=%0h/%0b exp=0/0", d_rsp_data, d_rsp_err); end
        total++; if (mem_en !== 1'b0 || mem_addr !== 32'd0 || mem_data_in !== 32'd0) begin bad++; $display("FAIL reset_mem got=%0b/%0h/%0h exp=0/0/0", mem_en, mem_addr, mem_data_in); end
        total++; if (if_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b/%0b exp=0/0", if_req_ready, d_req_ready); end
        idle_inputs();
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_if_reads();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h00100093; exp_w[1] = 32'h00200113; exp_w[2] = 32'h00300193;
        for (int i = 0; i < 3; i++) begin
            if_req_valid = 1'b1; if_req_addr = 32'(i * 4); if_rsp_ready = 1'b1;
            #1;
            total++; if (if_req_ready !== 1'b1) begin bad++; $display("FAIL ifrd_ready[%0d] got=%0b exp=1", i, if_req_ready); end
            total++; if (mem_en !== 1'b1 || mem_addr !== 32'(i * 4) || mem_data_in !== 32'd0) begin bad++; $display("FAIL ifrd_mem[%0d] got=%0b/%0h/%0h exp=1/%0h/0", i, mem_en, mem_addr, mem_data_in, i * 4); end
            @(posedge clk); #1;
            total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== exp_w[i] || if_rsp_err !== 1'b0) begin bad++; $display("FAIL ifrd_rsp[%0d] got=%0b/%0h/%0b exp=1/%0h/0", i, if_rsp_valid, if_rsp_data, if_rsp_err, exp_w[i]); end
        end
        if_req_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (if_rsp_valid !== 1'b0) begin bad++; $display("FAIL ifrd_drain got=%0b exp=0", if_rsp_valid); end
    endtask

    task automatic test_store_load();
        logic        exp_d;
        logic [31:0] exp_addr, exp_wd, exp_rd;
        do_reset();
        idle_inputs();
        for (int s = 0; s < 3; s++) begin
            if_req_valid = 1'b1; if_req_addr = 32'h10;
            d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_we = (s == 0); d_req_wdata = 32'hDEADBEEF;
            exp_d    = (s != 1);
            exp_addr = exp_d ? 32'h40 : 32'h10;
            exp_wd   = (s == 0) ? 32'hDEADBEEF : 32'd0;
            #1;
            total++; if (d_req_ready !== exp_d || if_req_ready !== !exp_d) begin bad++; $display("FAIL stld_grant[%0d] got=d%0b/if%0b exp=d%0b", s, d_req_ready, if_req_ready, exp_d); end
            total++; if (mem_addr !== exp_addr || mem_data_in !== exp_wd || mem_en !== 1'b1) begin bad++; $display("FAIL stld_mem[%0d] got=%0h/%0h exp=%0h/%0h", s, mem_addr, mem_data_in, exp_addr, exp_wd); end
            @(posedge clk); #1;
            if (exp_d) begin
                exp_rd = (s == 0) ? 32'd0 : 32'hDEADBEEF;
                total++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== exp_rd || d_rsp_err !== 1'b0) begin bad++; $display("FAIL stld_drsp[%0d] got=%0b/%0h/%0b exp=1/%0h/0", s, d_rsp_valid, d_rsp_data, d_rsp_err, exp_rd); end
            end else begin
                total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== init_word(4)) begin bad++; $display("FAIL stld_ifrsp[%0d] got=%0b/%0h exp=1/%0h", s, if_rsp_valid, if_rsp_data, init_word(4)); end
            end
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_starve();
        logic exp_d;
        int   seen_if;
        seen_if = -1;
        do_reset();
        idle_inputs();
        if_req_valid = 1'b1; if_req_addr = 32'h20;
        d_req_valid = 1'b1; d_req_addr = 32'h24;
        for (int k = 0; k < 6; k++) begin
            exp_d = (k % 2 == 0);
            #1;
            if (if_req_ready === 1'b1 && seen_if < 0) seen_if = k;
            total++; if (d_req_ready !== exp_d || if_req_ready !== !exp_d) begin bad++; $display("FAIL starve_grant[%0d] got=d%0b/if%0b exp=d%0b", k, d_req_ready, if_req_ready, exp_d); end
            @(posedge clk); #1;
            total++; if (dut.starve_cnt_reg !== (exp_d ? 4'd1 : 4'd0)) begin bad++; $display("FAIL starve_cnt[%0d] got=%0d exp=%0d", k, dut.starve_cnt_reg, exp_d ? 1 : 0); end
        end
        total++; if (seen_if < 0 || seen_if > 4) begin bad++; $display("FAIL starve_bound got=%0d exp<=4", seen_if); end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic        wes [3];
        addrs[0] = 32'h402; addrs[1] = 32'h400; addrs[2] = 32'h40;
        wes[0] = 1'b0; wes[1] = 1'b0; wes[2] = 1'b1;
        do_reset();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            d_req_valid = 1'b1; d_req_addr = addrs[i]; d_req_we = wes[i]; d_req_wdata = 32'd0;
            #1;
            total++; if (d_req_ready !== 1'b1 || mem_en !== 1'b0 || mem_data_in !== 32'd0) begin bad++; $display("FAIL err_req[%0d] got=%0b/%0b/%0h exp=1/0/0", i, d_req_ready, mem_en, mem_data_in); end
            @(posedge clk); #1;
            total++; if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b1 || d_rsp_data !== 32'd0) begin bad++; $display("FAIL err_rsp[%0d] got=%0b/%0b/%0h exp=1/1/0", i, d_rsp_valid, d_rsp_err, d_rsp_data); end
        end
        idle_inputs();
        @(posedge clk); #1;
        total++; if (mem_arr[16] !== 32'hDEADBEEF) begin bad++; $display("FAIL err_mem got=%0h exp=deadbeef", mem_arr[16]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        idle_inputs();
        if_req_valid = 1'b1; if_req_addr = 32'h0; if_rsp_ready = 1'b0;
        #1;
        total++; if (if_req_ready !== 1'b1) begin bad++; $display("FAIL bp_first got=%0b exp=1", if_req_ready); end
        @(posedge clk); #1;
        if_req_addr = 32'h4;
        d_req_valid = 1'b1; d_req_addr = 32'h8; d_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (if_req_ready !== 1'b0 || d_req_ready !== 1'b1) begin bad++; $display("FAIL bp_grant[%0d] got=if%0b/d%0b exp=if0/d1", i, if_req_ready, d_req_ready); end
            @(posedge clk); #1;
            total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h00100093 || d_rsp_data !== 32'h00300193) begin bad++; $display("FAIL bp_hold[%0d] got=%0b/%0h/%0h exp=1/100093/300193", i, if_rsp_valid, if_rsp_data, d_rsp_data); end
        end
        if_rsp_ready = 1'b1; d_req_valid = 1'b0;
        #1;
        total++; if (if_req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b exp=1", if_req_ready); end
        @(posedge clk); #1;
        total++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h00200113) begin bad++; $display("FAIL bp_reload got=%0b/%0h exp=1/200113", if_rsp_valid, if_rsp_data); end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        idle_inputs();
        if_req_valid = 1'b1; if_req_addr = 32'h8;
        @(posedge clk); #1;
        idle_inputs();
        total++; if (if_rsp_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%0b exp=1", if_rsp_valid); end
        #1;
        reset = 1'b1;
        #1;
        total++; if (if_rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_async got=%0b exp=0", if_rsp_valid); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_after[%0d] got=%0b/%0b exp=0/0", i, if_rsp_valid, d_rsp_valid); end
        end
    endtask

    task automatic test_random();
        logic        free_if, free_d, e_if, e_d, bad_req, exp_en;
        logic [31:0] exp_addr, exp_wd;
        int          win;
        int          mem_diff;
        reset = 1'b1; init_mem = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        init_mem = 1'b0; reset = 1'b0;
        m_if_v = 0; m_if_err = 0; m_if_data = 0; m_d_v = 0; m_d_err = 0; m_d_data = 0;
        m_prio_d = 1'b1; m_starve = 0;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        for (int c = 0; c < 400; c++) begin
            if_req_valid = ($urandom_range(0, 3) != 0); if_req_addr = rand_addr();
            if_rsp_ready = ($urandom_range(0, 3) != 0);
            d_req_valid  = ($urandom_range(0, 3) != 0); d_req_addr = rand_addr();
            d_req_we     = 1'($urandom_range(0, 1));
            d_req_wdata  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            d_rsp_ready  = ($urandom_range(0, 3) != 0);
            #1;
            free_if = !m_if_v || if_rsp_ready;
            free_d  = !m_d_v  || d_rsp_ready;
            e_if = if_req_valid && free_if;
            e_d  = d_req_valid && free_d;
            if (e_if && e_d) win = (m_starve >= 4) ? 1 : (m_prio_d ? 2 : 1);
            else if (e_if) win = 1;
            else if (e_d) win = 2;
            else win = 0;
            bad_req = 1'b0;
            if (win == 1) bad_req = (if_req_addr[1:0] != 0) || (if_req_addr >= 1024);
            if (win == 2) bad_req = (d_req_addr[1:0] != 0) || (d_req_addr >= 1024) || (d_req_we && d_req_wdata == 0);
            exp_en   = (win != 0) && !bad_req;
            exp_addr = (win == 2) ? d_req_addr : if_req_addr;
            exp_wd   = (exp_en && win == 2 && d_req_we) ? d_req_wdata : 32'd0;
            total++; if (if_req_ready !== (win == 1) || d_req_ready !== (win == 2)) begin bad++; $display("FAIL rnd_grant[%0d] got=if%0b/d%0b exp_win=%0d", c, if_req_ready, d_req_ready, win); end
            total++; if (mem_en !== exp_en || mem_data_in !== exp_wd || (exp_en && mem_addr !== exp_addr)) begin bad++; $display("FAIL rnd_mem[%0d] got=%0b/%0h/%0h exp=%0b/%0h/%0h", c, mem_en, mem_addr, mem_data_in, exp_en, exp_addr, exp_wd); end
            @(posedge clk); #1;
            if (win == 1) begin
                m_if_v = 1; m_if_err = bad_req; m_if_data = bad_req ? 32'd0 : shadow[if_req_addr[9:2]];
            end else if (if_rsp_ready) m_if_v = 0;
            if (win == 2) begin
                m_d_v = 1; m_d_err = bad_req; m_d_data = (bad_req || d_req_we) ? 32'd0 : shadow[d_req_addr[9:2]];
                if (!bad_req && d_req_we) shadow[d_req_addr[9:2]] = d_req_wdata;
            end else if (d_rsp_ready) m_d_v = 0;
            if (win == 1) m_starve = 0;
            else if (e_if && win == 2 && m_starve < 15) m_starve++;
            if (e_if && e_d) m_prio_d = (win == 1);
            total++; if (if_rsp_valid !== m_if_v || (m_if_v && (if_rsp_data !== m_if_data || if_rsp_err !== m_if_err))) begin bad++; $display("FAIL rnd_ifrsp[%0d] got=%0b/%0h/%0b exp=%0b/%0h/%0b", c, if_rsp_valid, if_rsp_data, if_rsp_err, m_if_v, m_if_data, m_if_err); end
            total++; if (d_rsp_valid !== m_d_v || (m_d_v && (d_rsp_data !== m_d_data || d_rsp_err !== m_d_err))) begin bad++; $display("FAIL rnd_drsp[%0d] got=%0b/%0h/%0b exp=%0b/%0h/%0b", c, d_rsp_valid, d_rsp_data, d_rsp_err, m_d_v, m_d_data, m_d_err); end
        end
        idle_inputs();
        @(posedge clk); #1;
        mem_diff = 0;
        for (int i = 0; i < 256; i++) if (mem_arr[i] !== shadow[i]) mem_diff++;
        total++; if (mem_diff != 0) begin bad++; $display("FAIL rnd_memory got=%0d differing words exp=0", mem_diff); end
    endtask

    initial begin
        test_reset();
        test_if_reads();
        test_store_load();
        test_starve();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
